// File: rtl/pc_seq_ctrl_pkg.sv
// Shared types and defaults for the program-counter sequencing controller.
// Imported by the interface, the fetch timer and the controller top.
package pc_seq_ctrl_pkg;

   localparam int unsigned PC_WIDTH_DEF = 16;
   localparam int unsigned TIMEOUT_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_ADVANCE = 2'd2,
      ST_HALTED  = 2'd3
   } state_e;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Bundle of controller-facing signals: run/halt, imem handshake, branch
// handshake and PC controls. master = controller side, slave = environment.
interface pc_seq_ctrl_if
   import pc_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = PC_WIDTH_DEF
) ();

   logic             run;
   logic             halt;
   logic             imem_req;
   logic             imem_ack;
   logic             instr_valid;
   logic             br_valid;
   logic [WIDTH-1:0] br_offset;
   logic             br_ready;
   logic             load;
   logic             inc;
   logic             add;
   logic             sub;
   logic [WIDTH-1:0] offset;
   logic             err;
   logic             busy;

   modport master (
      input  run, halt, imem_ack, br_valid, br_offset,
      output imem_req, instr_valid, br_ready, load, inc, add, sub, offset,
             err, busy
   );

   modport slave (
      output run, halt, imem_ack, br_valid, br_offset,
      input  imem_req, instr_valid, br_ready, load, inc, add, sub, offset,
             err, busy
   );

endinterface

// File: rtl/pc_seq_ctrl_fetch_timer.sv
// Counts cycles spent waiting for imem_ack; expired flags the last allowed
// wait cycle so the controller can abandon the fetch.
module fetch_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned   CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && (count_q != LAST)) begin
         count_q <= count_q + CW'(1);
      end
   end

   assign expired = en && (count_q == LAST);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Sequences the PC through fetch/advance, runs the imem req/ack handshake and
// turns accepted relative branches into add/sub + magnitude for the PC adder.
module pc_seq_ctrl
   import pc_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH   = PC_WIDTH_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   pc_seq_ctrl_if.master bus
);

   state_e           state_q;
   logic             imem_req_q;
   logic             instr_valid_q;
   logic             br_ready_q;
   logic             load_q;
   logic             inc_q;
   logic             add_q;
   logic             sub_q;
   logic [WIDTH-1:0] offset_q;
   logic             err_q;
   logic             busy_q;

   logic             br_neg;
   logic [WIDTH-1:0] br_mag_d;
   logic             timer_en;
   logic             timer_clr;
   logic             timer_exp;

   // Negative offsets become a subtract of the magnitude; 0x8000 negates to itself.
   always_comb begin
      br_neg   = bus.br_offset[WIDTH-1];
      br_mag_d = bus.br_offset;
      if (br_neg) begin
         br_mag_d = (~bus.br_offset) + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign timer_en  = (state_q == ST_FETCH) && !bus.imem_ack;
   assign timer_clr = !timer_en;

   fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_exp)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         br_ready_q    <= 1'b0;
         load_q        <= 1'b0;
         inc_q         <= 1'b0;
         add_q         <= 1'b0;
         sub_q         <= 1'b0;
         offset_q      <= '0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         instr_valid_q <= 1'b0;
         br_ready_q    <= 1'b0;
         load_q        <= 1'b0;
         inc_q         <= 1'b0;
         add_q         <= 1'b0;
         sub_q         <= 1'b0;
         offset_q      <= '0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.run && !bus.halt) begin
                  state_q    <= ST_FETCH;
                  imem_req_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ST_FETCH: begin
               // Ack wins over a simultaneous timeout: the word did arrive.
               if (bus.imem_ack) begin
                  state_q       <= ST_ADVANCE;
                  imem_req_q    <= 1'b0;
                  instr_valid_q <= 1'b1;
                  load_q        <= 1'b1;
                  br_ready_q    <= 1'b1;
                  if (bus.br_valid) begin
                     add_q    <= !br_neg;
                     sub_q    <= br_neg;
                     offset_q <= br_mag_d;
                  end else begin
                     inc_q <= 1'b1;
                  end
               end else if (timer_exp) begin
                  state_q    <= ST_HALTED;
                  imem_req_q <= 1'b0;
                  err_q      <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            ST_ADVANCE: begin
               if (bus.halt || !bus.run) begin
                  state_q <= ST_HALTED;
                  busy_q  <= 1'b0;
               end else begin
                  state_q    <= ST_FETCH;
                  imem_req_q <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (bus.run && !bus.halt && !err_q) begin
                  state_q    <= ST_FETCH;
                  imem_req_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               imem_req_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = imem_req_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.br_ready    = br_ready_q;
   assign bus.load        = load_q;
   assign bus.inc         = inc_q;
   assign bus.add         = add_q;
   assign bus.sub         = sub_q;
   assign bus.offset      = offset_q;
   assign bus.err         = err_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: a behavioural PC follows the load/inc/add/sub
// pulses and each scenario task compares against hand-computed values.
module tb_pc_seq_ctrl;

   localparam int unsigned W  = 16;
   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_load = 0;
   int          n_iv = 0;
   logic [15:0] pc_m = '0;

   pc_seq_ctrl_if #(.WIDTH(W)) bus ();

   pc_seq_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [24:0] outs();
      return {bus.imem_req, bus.instr_valid, bus.br_ready, bus.load, bus.inc,
              bus.add, bus.sub, bus.err, bus.busy, bus.offset};
   endfunction

   // Advance one cycle and apply whatever PC update the controller issued.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.load) begin
         n_load++;
         if (bus.inc)      pc_m = pc_m + 16'd1;
         else if (bus.add) pc_m = pc_m + bus.offset;
         else if (bus.sub) pc_m = pc_m - bus.offset;
      end
      if (bus.instr_valid) n_iv++;
   endtask

   task automatic apply_reset();
      bus.run = 1'b0; bus.halt = 1'b0; bus.imem_ack = 1'b0;
      bus.br_valid = 1'b0; bus.br_offset = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      n_load = 0;
      n_iv = 0;
   endtask

   task automatic wait_req(output bit ok);
      int n = 0;
      while (!bus.imem_req && n < 20) begin
         step();
         n++;
      end
      ok = bus.imem_req;
   endtask

   // One fetch: wait for req, stall wait_cyc cycles, ack, sample ADVANCE outputs.
   task automatic do_fetch(input int wait_cyc, input logic bv, input logic [15:0] bo,
                           output bit ok, output logic [3:0] ctl, output logic [15:0] off);
      bit got;
      bus.br_valid = bv;
      bus.br_offset = bo;
      wait_req(got);
      if (!got) begin
         ok = 1'b0; ctl = '0; off = '0; bus.br_valid = 1'b0;
         return;
      end
      repeat (wait_cyc) step();
      bus.imem_ack = 1'b1;
      step();
      bus.imem_ack = 1'b0;
      ctl = {bus.load, bus.inc, bus.add, bus.sub};
      off = bus.offset;
      ok = bus.instr_valid && bus.br_ready;
      bus.br_valid = 1'b0;
   endtask

   task automatic test_reset();
      int  n;
      bit  load_seen;
      bus.run = 1'b0; bus.halt = 1'b0; bus.imem_ack = 1'b0;
      bus.br_valid = 1'b0; bus.br_offset = '0;
      reset = 1'b0;
      #12;
      n_cmp++;
      if (outs() !== 25'd0) begin
         n_bad++; $display("FAIL reset_outs: got %h expected %h", outs(), 25'd0);
      end
      reset = 1'b1;
      bus.run = 1'b1;
      n = 0;
      while (!bus.imem_req && n < 5) begin step(); n++; end
      n_cmp++;
      if (!(bus.imem_req === 1'b1 && n <= 2)) begin
         n_bad++; $display("FAIL first_req: got req=%b after %0d cycles expected req=1 within 2", bus.imem_req, n);
      end
      step(); step();
      #3;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (outs() !== 25'd0) begin
         n_bad++; $display("FAIL reset_midfetch: got %h expected %h", outs(), 25'd0);
      end
      load_seen = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus.load !== 1'b0) load_seen = 1'b1;
      end
      n_cmp++;
      if (load_seen !== 1'b0) begin
         n_bad++; $display("FAIL reset_noload: got load_seen=%b expected 0", load_seen);
      end
      reset = 1'b1;
      n = 0;
      while (!bus.imem_req && n < 5) begin step(); n++; end
      n_cmp++;
      if (!(bus.imem_req === 1'b1 && n <= 2)) begin
         n_bad++; $display("FAIL req_after_reset: got req=%b after %0d cycles expected req=1 within 2", bus.imem_req, n);
      end
   endtask

   task automatic test_seq_fetch();
      bit          ok;
      logic [3:0]  ctl;
      logic [15:0] off;
      int          t[4];
      apply_reset();
      pc_m = 16'h0000;
      bus.run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_fetch(0, 1'b0, 16'h0000, ok, ctl, off);
         t[i] = cyc;
         if (i == 3) bus.run = 1'b0;
         n_cmp++;
         if (!(ok && ctl === 4'b1100 && off === 16'h0000)) begin
            n_bad++; $display("FAIL seq_ctl[%0d]: got ok=%b ctl=%b off=%h expected ok=1 ctl=1100 off=0000", i, ok, ctl, off);
         end
      end
      for (int i = 1; i < 4; i++) begin
         n_cmp++;
         if (t[i] - t[i-1] !== 2) begin
            n_bad++; $display("FAIL seq_spacing[%0d]: got %0d expected 2", i, t[i] - t[i-1]);
         end
      end
      step(); step();
      n_cmp++;
      if (!(n_load == 4 && n_iv == 4 && pc_m === 16'h0004)) begin
         n_bad++; $display("FAIL seq_totals: got loads=%0d iv=%0d pc=%h expected 4 4 0004", n_load, n_iv, pc_m);
      end
      n_cmp++;
      if ({bus.busy, bus.imem_req} !== 2'b00) begin
         n_bad++; $display("FAIL seq_stop: got busy=%b req=%b expected 0 0", bus.busy, bus.imem_req);
      end
   endtask

   task automatic test_branch();
      bit          ok;
      logic [3:0]  ctl;
      logic [15:0] off;
      apply_reset();
      pc_m = 16'h0010;
      bus.run = 1'b1;
      bus.br_valid = 1'b1;
      bus.br_offset = 16'h0005;
      wait_req(ok);
      n_cmp++;
      if (!(ok && bus.br_ready === 1'b0 && bus.load === 1'b0)) begin
         n_bad++; $display("FAIL br_outside_adv: got req=%b br_ready=%b load=%b expected 1 0 0", ok, bus.br_ready, bus.load);
      end
      do_fetch(1, 1'b1, 16'h0005, ok, ctl, off);
      n_cmp++;
      if (!(ok && ctl === 4'b1010 && off === 16'h0005 && pc_m === 16'h0015)) begin
         n_bad++; $display("FAIL br_fwd: got ok=%b ctl=%b off=%h pc=%h expected 1 1010 0005 0015", ok, ctl, off, pc_m);
      end
      do_fetch(0, 1'b1, 16'hFFFD, ok, ctl, off);
      n_cmp++;
      if (!(ok && ctl === 4'b1001 && off === 16'h0003 && pc_m === 16'h0012)) begin
         n_bad++; $display("FAIL br_back: got ok=%b ctl=%b off=%h pc=%h expected 1 1001 0003 0012", ok, ctl, off, pc_m);
      end
      bus.run = 1'b0;
      step(); step();
   endtask

   task automatic test_edge_offsets();
      bit          ok;
      logic [3:0]  ctl;
      logic [15:0] off;
      apply_reset();
      pc_m = 16'h0012;
      bus.run = 1'b1;
      do_fetch(0, 1'b1, 16'h8000, ok, ctl, off);
      n_cmp++;
      if (!(ok && ctl === 4'b1001 && off === 16'h8000 && pc_m === 16'h8012)) begin
         n_bad++; $display("FAIL br_min_neg: got ok=%b ctl=%b off=%h pc=%h expected 1 1001 8000 8012", ok, ctl, off, pc_m);
      end
      do_fetch(0, 1'b1, 16'h0000, ok, ctl, off);
      n_cmp++;
      if (!(ok && ctl === 4'b1010 && off === 16'h0000 && pc_m === 16'h8012)) begin
         n_bad++; $display("FAIL br_zero: got ok=%b ctl=%b off=%h pc=%h expected 1 1010 0000 8012", ok, ctl, off, pc_m);
      end
      bus.run = 1'b0;
      step(); step();
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      apply_reset();
      bus.run = 1'b1;
      wait_req(ok);
      n = 0;
      while (bus.imem_req && n < 40) begin
         n++;
         step();
      end
      n_cmp++;
      if (n !== 16) begin
         n_bad++; $display("FAIL timeout_len: got %0d fetch cycles expected 16", n);
      end
      n_cmp++;
      if ({bus.err, bus.imem_req, bus.busy} !== 3'b100) begin
         n_bad++; $display("FAIL timeout_err: got err/req/busy=%b expected 100", {bus.err, bus.imem_req, bus.busy});
      end
      repeat (5) step();
      n_cmp++;
      if (!(bus.imem_req === 1'b0 && bus.err === 1'b1 && n_load == 0)) begin
         n_bad++; $display("FAIL timeout_sticky: got req=%b err=%b loads=%0d expected 0 1 0", bus.imem_req, bus.err, n_load);
      end
      apply_reset();
      #1;
      n_cmp++;
      if (outs() !== 25'd0) begin
         n_bad++; $display("FAIL timeout_clear: got %h expected %h", outs(), 25'd0);
      end
   endtask

   task automatic test_halt_fetch();
      bit ok;
      int n;
      int l0;
      apply_reset();
      bus.run = 1'b1;
      wait_req(ok);
      bus.halt = 1'b1;
      repeat (3) step();
      n_cmp++;
      if (bus.imem_req !== 1'b1) begin
         n_bad++; $display("FAIL halt_keeps_fetch: got req=%b expected 1", bus.imem_req);
      end
      bus.imem_ack = 1'b1;
      step();
      bus.imem_ack = 1'b0;
      n_cmp++;
      if ({bus.load, bus.inc, bus.add, bus.sub} !== 4'b1100) begin
         n_bad++; $display("FAIL halt_advance: got ctl=%b expected 1100", {bus.load, bus.inc, bus.add, bus.sub});
      end
      step();
      n_cmp++;
      if ({bus.busy, bus.imem_req, bus.load} !== 3'b000) begin
         n_bad++; $display("FAIL halt_state: got busy/req/load=%b expected 000", {bus.busy, bus.imem_req, bus.load});
      end
      l0 = n_load;
      repeat (3) step();
      n_cmp++;
      if (!(n_load == l0 && l0 == 1 && bus.imem_req === 1'b0)) begin
         n_bad++; $display("FAIL halt_hold: got loads=%0d req=%b expected 1 0", n_load, bus.imem_req);
      end
      bus.halt = 1'b0;
      n = 0;
      while (!bus.imem_req && n < 5) begin step(); n++; end
      n_cmp++;
      if (!(bus.imem_req === 1'b1 && n <= 2)) begin
         n_bad++; $display("FAIL halt_resume: got req=%b after %0d cycles expected req=1 within 2", bus.imem_req, n);
      end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_branch();
      test_edge_offsets();
      test_timeout();
      test_halt_fetch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
